// File: rtl/dmem_ctrl.sv
// Load/store sequencer between the memory stage and a word-addressed, byte-masked data memory.
// Define DMEM_CTRL_MISALIGN_EN to split word-crossing accesses in two; otherwise such accesses are rejected.
module dmem_ctrl #(
  parameter int REG_SIZE  = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [REG_SIZE-1:0] req_addr_i,
  input  logic [REG_SIZE-1:0] req_wdata_i,
  output logic                resp_valid_o,
  output logic [REG_SIZE-1:0] resp_rdata_o,
  output logic                resp_err_o,
  output logic                mem_cs_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_mask_o,
  output logic [REG_SIZE-1:0] mem_addr_o,
  output logic [REG_SIZE-1:0] mem_wdata_o,
  input  logic [REG_SIZE-1:0] mem_rdata_i
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t state, state_nxt;

  logic                we_q;
  logic [2:0]          f3_q;
  logic [REG_SIZE-1:0] addr_q, wdata_q, lo_q;
`ifdef DMEM_CTRL_MISALIGN_EN
  logic [REG_SIZE-1:0]   hi_q;
  logic [2*REG_SIZE-1:0] wsh;
`else
  logic [REG_SIZE-1:0]   wsh;
`endif
  logic [1:0]          off;
  logic [4:0]          sh;
  logic [AW-1:0]       idx, idx_nxt;
  logic [3:0]          base;
  logic [6:0]          mask7;
  logic                split, illegal;
  logic [REG_SIZE-1:0] rd_al, rd_ext;
  logic                unused_addr;

  assign off         = addr_q[1:0];
  assign sh          = {off, 3'b000};
  assign idx         = addr_q[AW+1:2];
  assign idx_nxt     = (idx == AW'(MEM_WORDS - 1)) ? '0 : idx + AW'(1);
  assign unused_addr = ^addr_q[REG_SIZE-1:AW+2];

  always_comb begin
    base = 4'b0000;
    case (f3_q[1:0])
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      2'd2:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
  end

  // Bits [6:4] of the shifted mask are the lanes that spill into the next word.
  assign mask7 = {3'b000, base} << off;
  assign split = |mask7[6:4];

  always_comb begin
    illegal = we_q ? (f3_q > 3'd2) : (f3_q == 3'd3 || f3_q > 3'd5);
`ifndef DMEM_CTRL_MISALIGN_EN
    illegal = illegal | split;
`endif
  end

`ifdef DMEM_CTRL_MISALIGN_EN
  assign wsh   = {{REG_SIZE{1'b0}}, wdata_q} << sh;
  assign rd_al = REG_SIZE'({hi_q, lo_q} >> sh);
`else
  assign wsh   = wdata_q << sh;
  assign rd_al = lo_q >> sh;
`endif

  always_comb begin
    rd_ext = rd_al;
    case (f3_q)
      3'd0:    rd_ext = {{(REG_SIZE-8){rd_al[7]}}, rd_al[7:0]};
      3'd1:    rd_ext = {{(REG_SIZE-16){rd_al[15]}}, rd_al[15:0]};
      3'd4:    rd_ext = {{(REG_SIZE-8){1'b0}}, rd_al[7:0]};
      3'd5:    rd_ext = {{(REG_SIZE-16){1'b0}}, rd_al[15:0]};
      default: rd_ext = rd_al;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
`ifdef DMEM_CTRL_MISALIGN_EN
      hi_q    <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      if (state == ACC0) lo_q <= mem_rdata_i;
`ifdef DMEM_CTRL_MISALIGN_EN
      if (state == ACC1) hi_q <= mem_rdata_i;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    resp_rdata_o = '0;
    mem_cs_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_mask_o   = 4'b0000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = ACC0;
      end
      ACC0: begin
        if (!illegal) begin
          mem_cs_o    = 1'b1;
          mem_we_o    = we_q;
          mem_mask_o  = we_q ? mask7[3:0] : 4'b0000;
          mem_addr_o  = {{(REG_SIZE-AW){1'b0}}, idx};
          mem_wdata_o = wsh[REG_SIZE-1:0];
        end
`ifdef DMEM_CTRL_MISALIGN_EN
        state_nxt = (!illegal && split) ? ACC1 : RESP;
`else
        state_nxt = RESP;
`endif
      end
`ifdef DMEM_CTRL_MISALIGN_EN
      ACC1: begin
        // A reset landing here must not let the second half reach memory.
        mem_cs_o    = !rst_i;
        mem_we_o    = we_q && !rst_i;
        mem_mask_o  = (we_q && !rst_i) ? {1'b0, mask7[6:4]} : 4'b0000;
        mem_addr_o  = {{(REG_SIZE-AW){1'b0}}, idx_nxt};
        mem_wdata_o = wsh[2*REG_SIZE-1:REG_SIZE];
        state_nxt   = RESP;
      end
`endif
      RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = illegal;
        resp_rdata_o = (we_q || illegal) ? '0 : rd_ext;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl with a byte-array reference memory and per-cycle output checks.
module tb_dmem_ctrl;
  localparam int MW = 256;
  localparam int NB = 4 * MW;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_cs, mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.REG_SIZE(32), .MEM_WORDS(MW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_mask_o(mem_mask),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  logic [31:0] dmem [MW];
  logic        mem_init;
  logic [7:0]  refm [NB];
  int total = 0;
  int passed = 0;

  function automatic logic [31:0] pattern(input int w);
    logic [31:0] wv;
    wv = 32'(w);
    return (wv * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = dmem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < MW; w++) dmem[w] <= pattern(w);
    end else if (mem_cs && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) dmem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] g_rd, output logic g_err,
                        output logic [31:0] g_a0, output logic [3:0] g_m0, output logic [31:0] g_w0,
                        output logic [31:0] g_a1, output logic [3:0] g_m1, output logic [31:0] g_w1,
                        output int g_lat);
    int n, o, lane, wait_k, ba;
    bit legal, split, seen;
    logic [3:0]  m0, m1;
    logic [31:0] w0, w1, erd, a0, a1;
    logic [7:0]  bt;
    o = int'(addr[1:0]);
    case (f3[1:0])
      2'd0: n = 1;
      2'd1: n = 2;
      2'd2: n = 4;
      default: n = 0;
    endcase
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 >= 3'd6);
    split = (o + n) > 4;
`ifndef DMEM_CTRL_MISALIGN_EN
    if (split) legal = 1'b0;
`endif
    a0 = (addr >> 2) % 32'(MW);
    a1 = (a0 + 32'd1) % 32'(MW);
    m0 = '0; m1 = '0; w0 = '0; w1 = '0;
    for (int i = 0; i < n; i++) begin
      lane = o + i;
      if (lane < 4) m0[lane] = 1'b1; else m1[lane-4] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      lane = o + i;
      bt = wd[8*i +: 8];
      if (lane < 4) w0[8*lane +: 8] = bt; else w1[8*(lane-4) +: 8] = bt;
    end
    erd = '0;
    if (legal && !we) begin
      for (int i = 0; i < n; i++) begin
        ba = int'((addr + 32'(i)) % 32'(NB));
        erd[8*i +: 8] = refm[ba];
      end
      if (f3 == 3'd0 && erd[7])  erd[31:8]  = '1;
      if (f3 == 3'd1 && erd[15]) erd[31:16] = '1;
    end

    g_rd = '0; g_err = 1'b0; g_a0 = '0; g_m0 = '0; g_w0 = '0;
    g_a1 = '0; g_m1 = '0; g_w1 = '0; g_lat = 0; seen = 1'b0;
    wait_k = 0;
    while (!req_ready && wait_k < 8) begin @(negedge clk); wait_k++; end
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 5 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1; g_lat = k; g_rd = resp_rdata; g_err = resp_err;
        chk("resp_cs", 32'(mem_cs), 32'd0);
      end else begin
        chk("busy_ready", 32'(req_ready), 32'd0);
        if (k == 1) begin
          chk("acc0_cs", 32'(mem_cs), 32'(legal));
          chk("acc0_we", 32'(mem_we), 32'(legal && we));
          if (legal) begin
            g_a0 = mem_addr; g_m0 = mem_mask; g_w0 = mem_wdata;
            chk("acc0_addr", mem_addr, a0);
            chk("acc0_mask", 32'(mem_mask), we ? 32'(m0) : 32'd0);
            if (we) chk("acc0_wdata", mem_wdata, w0);
          end
        end else if (k == 2 && legal && split) begin
          g_a1 = mem_addr; g_m1 = mem_mask; g_w1 = mem_wdata;
          chk("acc1_cs", 32'(mem_cs), 32'd1);
          chk("acc1_we", 32'(mem_we), 32'(we));
          chk("acc1_addr", mem_addr, a1);
          chk("acc1_mask", 32'(mem_mask), we ? 32'(m1) : 32'd0);
          if (we) chk("acc1_wdata", mem_wdata, w1);
        end else begin
          chk("idle_cs", 32'(mem_cs), 32'd0);
          chk("idle_we", 32'(mem_we), 32'd0);
        end
      end
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("latency", 32'(g_lat), (legal && split) ? 32'd3 : 32'd2);
    chk("resp_err", 32'(g_err), 32'(!legal));
    chk("resp_rdata", g_rd, erd);
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    if (legal && we)
      for (int i = 0; i < n; i++) refm[int'((addr + 32'(i)) % 32'(NB))] = wd[8*i +: 8];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a0, w0, a1, w1, addr, wd, pw, old0, word;
    logic [3:0]  m0, m1;
    logic        err, we;
    logic [2:0]  f3;
    int          lat, bad;

    for (int w = 0; w < MW; w++) begin
      pw = pattern(w);
      for (int b = 0; b < 4; b++) refm[4*w+b] = pw[8*b +: 8];
    end
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_f3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_mask", 32'(mem_mask), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("sw_addr", a0, 32'd4);
    chk("sw_mask", 32'(m0), 32'hF);
    chk("sw_wdata", w0, 32'hDEADBEEF);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(err), 32'd0);
    do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("sb_mask", 32'(m0), 32'h8);
    chk("sb_wdata", w0, 32'hA5000000);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("lb_rdata", rd, 32'hFFFFFFA5);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("lbu_rdata", rd, 32'h000000A5);
    do_req(1'b1, 3'd4, 32'h20, 32'h12345678, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("st_f3_4_err", 32'(err), 32'd1);
    chk("st_f3_4_rdata", rd, 32'd0);

`ifdef DMEM_CTRL_MISALIGN_EN
    do_req(1'b1, 3'd2, 32'h0C, 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    do_req(1'b1, 3'd2, 32'h10, 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    do_req(1'b1, 3'd2, 32'h0E, 32'h11223344, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("split_a0", a0, 32'd3);
    chk("split_m0", 32'(m0), 32'hC);
    chk("split_w0", w0, 32'h33440000);
    chk("split_a1", a1, 32'd4);
    chk("split_m1", 32'(m1), 32'h3);
    chk("split_w1", w1, 32'h00001122);
    chk("split_lat", 32'(lat), 32'd3);
    do_req(1'b0, 3'd2, 32'h0E, 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("split_lw", rd, 32'h11223344);
    do_req(1'b0, 3'd2, 32'(4*MW-2), 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("wrap_a1", a1, 32'd0);

    old0 = dmem[0];
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'(4*MW-2); req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_acc0_addr", mem_addr, 32'(MW-1));
    chk("rst_acc0_mask", 32'(mem_mask), 32'hC);
    @(negedge clk);
    chk("rst_acc1_addr", mem_addr, 32'd0);
    chk("rst_acc1_cs", 32'(mem_cs), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_gates_cs", 32'(mem_cs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_no_resp", 32'(resp_valid), 32'd0);
    chk("rst_ready_next", 32'(req_ready), 32'd1);
    chk("rst_word0_kept", dmem[0], old0);
    word = dmem[MW-1];
    chk("rst_half_written", 32'(word[31:16]), 32'hF00D);
    refm[NB-2] = 8'h0D;
    refm[NB-1] = 8'hF0;
    @(negedge clk);
`else
    do_req(1'b0, 3'd1, 32'h07, 32'h0, rd, err, a0, m0, w0, a1, m1, w1, lat);
    chk("lh_mis_err", 32'(err), 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
    chk("lh_mis_lat", 32'(lat), 32'd2);
`endif

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(3, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      addr = $urandom;
      addr[9:6] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
      wd = $urandom;
      do_req(we, f3, addr, wd, rd, err, a0, m0, w0, a1, m1, w1, lat);
    end

    bad = 0;
    for (int w = 0; w < MW; w++) begin
      word = {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};
      if (dmem[w] !== word) bad++;
    end
    chk("mem_final_bad_words", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
